// File: rtl/hilotof_echo_dut.sv
// HiLoTOF DUT-side echo endpoint: FIFO-buffered, XOR-transformed word loopback
// with a checksum trailer appended after every FRAME_LEN data words.
module hilotof_echo_dut #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int          FRAME_LEN  = 8,
  parameter logic [31:0] XOR_MASK   = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        din_valid,
  input  logic [31:0] din,
  input  logic        dout_ready,
  output logic        dout_valid,
  output logic [31:0] dout,
  output logic        overflow,
  output logic [15:0] frame_count
);

  // state      | meaning
  // ST_DATA    | forwarding FIFO words into the output slot
  // ST_TRAILER | frame complete, next free slot carries the checksum
  typedef enum logic {ST_DATA, ST_TRAILER} state_t;

  localparam int              DEPTH    = 1 << DEPTH_LOG2;
  localparam int              CW       = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]     FRAME_W  = 16'(FRAME_LEN);

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [31:0]           dout_q, dout_d;
  logic                  is_trailer_q, is_trailer_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [31:0]           sum_q, sum_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  state_t                state_q, state_d;

  logic        slot_free;
  logic        pop;
  logic        push;
  logic [31:0] head;

  assign head = mem_q[rd_ptr_q] ^ XOR_MASK;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    dout_valid_d  = dout_valid_q;
    dout_d        = dout_q;
    is_trailer_d  = is_trailer_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    sum_d         = sum_q;
    word_cnt_d    = word_cnt_q;
    state_d       = state_q;
    pop           = 1'b0;
    push          = 1'b0;

    slot_free = !dout_valid_q || dout_ready;

    // A free slot empties unless something is loaded below; dout keeps its value.
    if (slot_free) begin
      dout_valid_d = 1'b0;
      is_trailer_d = 1'b0;
    end

    case (state_q)
      ST_DATA: begin
        if (slot_free && (count_q != '0) && (word_cnt_q < FRAME_W)) begin
          pop          = 1'b1;
          dout_d       = head;
          dout_valid_d = 1'b1;
          sum_d        = sum_q + head;
          word_cnt_d   = word_cnt_q + 16'd1;
          if (word_cnt_d == FRAME_W) begin
            state_d = ST_TRAILER;
          end
        end
      end
      ST_TRAILER: begin
        if (slot_free) begin
          dout_d       = sum_q;
          dout_valid_d = 1'b1;
          is_trailer_d = 1'b1;
          sum_d        = '0;
          word_cnt_d   = '0;
          state_d      = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push = din_valid && ((count_q != FULL_CNT) || pop);
    if (din_valid && !push) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (dout_valid_q && dout_ready && is_trailer_q) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dout_valid_q  <= 1'b0;
      dout_q        <= '0;
      is_trailer_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
      sum_q         <= '0;
      word_cnt_q    <= '0;
      state_q       <= ST_DATA;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dout_valid_q  <= dout_valid_d;
      dout_q        <= dout_d;
      is_trailer_q  <= is_trailer_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      sum_q         <= sum_d;
      word_cnt_q    <= word_cnt_d;
      state_q       <= state_d;
    end
  end

  assign dout_valid  = dout_valid_q;
  assign dout        = dout_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule
